// File: rtl/clk_gate_ctrl_if.sv
// Per-channel wake/activity handshake between requesters and the clock-gate controller.
interface clk_gate_ctrl_if #(
    parameter int unsigned CH = 4
);
    logic [CH-1:0] ch_req;
    logic [CH-1:0] ch_busy;
    logic [CH-1:0] ch_force;
    logic [CH-1:0] ch_en;
    logic [CH-1:0] ch_ack;

    // Requester side: raises activity, observes enable/ack.
    modport master (
        output ch_req,
        output ch_busy,
        output ch_force,
        input  ch_en,
        input  ch_ack
    );

    // Controller side: samples activity, drives enable/ack.
    modport slave (
        input  ch_req,
        input  ch_busy,
        input  ch_force,
        output ch_en,
        output ch_ack
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gate controller: per-channel OFF/WAKE/ON/IDLE FSM with
// wake-up latency, ack handshake, idle hysteresis and scan-enable override.
module clk_gate_ctrl #(
    parameter int unsigned CH       = 4,
    parameter int unsigned IDLE_W   = 8,
    parameter int unsigned WAKE_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              se_i,
    input  logic [IDLE_W-1:0] cfg_idle_thr_i,
    clk_gate_ctrl_if.slave    gate,
    output logic              all_off_o
);

    localparam int unsigned WAKE_W = 4;
    // Wake counter preload; unused when WAKE_LAT is zero (OFF goes straight to ON).
    localparam logic [WAKE_W-1:0] WAKE_INIT = (WAKE_LAT == 0) ? '0 : WAKE_W'(WAKE_LAT - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t            state_q    [CH];
    state_t            state_d    [CH];
    logic [WAKE_W-1:0] wake_cnt_q [CH];
    logic [WAKE_W-1:0] wake_cnt_d [CH];
    logic [IDLE_W-1:0] idle_cnt_q [CH];
    logic [IDLE_W-1:0] idle_cnt_d [CH];

    logic [CH-1:0] act;
    logic [CH-1:0] en_st;
    logic [CH-1:0] ack_st;

    assign act = gate.ch_req | gate.ch_busy | gate.ch_force;

    // State and counter registers; reset aborts any channel in flight.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(CH); i++) begin
            if (rst_i) begin
                state_q[i]    <= ST_OFF;
                wake_cnt_q[i] <= '0;
                idle_cnt_q[i] <= '0;
            end else begin
                state_q[i]    <= state_d[i];
                wake_cnt_q[i] <= wake_cnt_d[i];
                idle_cnt_q[i] <= idle_cnt_d[i];
            end
        end
    end

    // Per-channel next-state; counters only decrement while nonzero.
    always_comb begin
        for (int i = 0; i < int'(CH); i++) begin
            state_d[i]    = state_q[i];
            wake_cnt_d[i] = wake_cnt_q[i];
            idle_cnt_d[i] = idle_cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (act[i]) begin
                        if (WAKE_LAT == 0) begin
                            state_d[i] = ST_ON;
                        end else begin
                            state_d[i]    = ST_WAKE;
                            wake_cnt_d[i] = WAKE_INIT;
                        end
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_q[i] == '0) begin
                        state_d[i] = ST_ON;
                    end else begin
                        wake_cnt_d[i] = wake_cnt_q[i] - WAKE_W'(1);
                    end
                end
                ST_ON: begin
                    if (!act[i]) begin
                        if (cfg_idle_thr_i == '0) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i]    = ST_IDLE;
                            idle_cnt_d[i] = cfg_idle_thr_i - IDLE_W'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (act[i]) begin
                        state_d[i] = ST_ON;
                    end else if (idle_cnt_q[i] == '0) begin
                        state_d[i] = ST_OFF;
                    end else begin
                        idle_cnt_d[i] = idle_cnt_q[i] - IDLE_W'(1);
                    end
                end
                default: state_d[i] = ST_OFF;
            endcase
        end
    end

    // Output decode from state registers only.
    always_comb begin
        en_st  = '0;
        ack_st = '0;
        for (int i = 0; i < int'(CH); i++) begin
            en_st[i]  = (state_q[i] != ST_OFF);
            ack_st[i] = (state_q[i] == ST_ON) || (state_q[i] == ST_IDLE);
        end
    end

    // Scan enable overrides the gate enables only; ack and FSMs are untouched.
    assign gate.ch_en  = en_st | {CH{se_i}};
    assign gate.ch_ack = ack_st;
    assign all_off_o   = (en_st == '0) && !se_i;

endmodule
